// File: rtl/scaler_step_ctrl.sv
// -----------------------------------------------------------------------------
// scaler_step_ctrl
//
// Configuration sequencer for the horizontal cubic scaler. Takes an input /
// output line width pair and computes scale_step = in_width * PIXEL_STEP /
// out_width with a serial restoring divider. The result is held as pending
// and only becomes the active step at a frame start (de_i & vs_i), so a frame
// is never scaled with mixed steps.
//
// Ports
//   clk            system clock, rising edge
//   rst            asynchronous, active-high reset
//   cfg_in_width   source line width in pixels
//   cfg_out_width  destination line width in pixels
//   cfg_valid      config request
//   cfg_ready      config can be accepted this cycle
//   cfg_err        one-cycle pulse: request rejected (a width was zero)
//   de_i/hs_i/vs_i scaler input syncs (hs_i reserved, unused)
//   scale_step     active step, wired to the scaler
//   step_upd       one-cycle pulse: scale_step changed this cycle
//   step_sat       active step was clamped
//   busy           division in progress
//
// state | meaning
// ------+------------------------------------------------
// IDLE  | nothing pending
// DIV   | serial division running, one quotient bit/cycle
// PEND  | result held, waiting for a frame start
// -----------------------------------------------------------------------------
module scaler_step_ctrl #(
    parameter int PIXEL_STEP = 4096,
    parameter int W_WIDTH    = 13
) (
    input  logic               clk,
    input  logic               rst,
    input  logic [W_WIDTH-1:0] cfg_in_width,
    input  logic [W_WIDTH-1:0] cfg_out_width,
    input  logic               cfg_valid,
    output logic               cfg_ready,
    output logic               cfg_err,
    input  logic               de_i,
    input  logic               hs_i,
    input  logic               vs_i,
    output logic [15:0]        scale_step,
    output logic               step_upd,
    output logic               step_sat,
    output logic               busy
);

    localparam int PB       = $clog2(PIXEL_STEP);
    localparam int NUM_BITS = W_WIDTH + PB;
    localparam int CW       = $clog2(NUM_BITS);
    // Quotient is compared against 16'hFFFF at a width that fits both.
    localparam int QW       = (NUM_BITS > 16) ? NUM_BITS : 16;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_DIV  = 2'd1;
    localparam logic [1:0] ST_PEND = 2'd2;

    logic [1:0]          state;
    logic [NUM_BITS-1:0] num;
    logic [W_WIDTH-1:0]  den;
    logic [NUM_BITS-1:0] quo;
    logic [W_WIDTH:0]    rem;
    logic [CW-1:0]       cnt;
    logic [15:0]         pending;
    logic                pending_sat;
    logic                apply_q;
    logic                err_q;

    logic                frame_start;
    logic                accept;
    logic                cfg_zero;
    logic                do_load;
    logic [W_WIDTH:0]    rem_shift;
    logic                sub_ok;
    logic [W_WIDTH:0]    rem_next;
    logic [NUM_BITS-1:0] quo_next;
    logic [QW-1:0]       quo_ext;
    logic [1:0]          unused_bits;

    // hs_i is reserved for line-granular updates; rem's MSB is always zero
    // after a restoring step because rem < den.
    assign unused_bits = {hs_i, rem[W_WIDTH]};

    assign frame_start = de_i & vs_i;
    assign cfg_ready   = (state != ST_DIV);
    assign busy        = (state == ST_DIV);
    assign accept      = cfg_valid & cfg_ready;
    assign cfg_zero    = (cfg_in_width == '0) | (cfg_out_width == '0);
    assign do_load     = accept & ~cfg_zero;

    // One restoring step: bring in the next numerator bit, subtract if it fits.
    assign rem_shift = {rem[W_WIDTH-1:0], num[NUM_BITS-1]};
    assign sub_ok    = (rem_shift >= {1'b0, den});
    assign rem_next  = sub_ok ? (rem_shift - {1'b0, den}) : rem_shift;
    assign quo_next  = {quo[NUM_BITS-2:0], sub_ok};
    assign quo_ext   = QW'(quo_next);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= ST_IDLE;
            num         <= '0;
            den         <= '0;
            quo         <= '0;
            rem         <= '0;
            cnt         <= '0;
            pending     <= '0;
            pending_sat <= 1'b0;
            apply_q     <= 1'b0;
            err_q       <= 1'b0;
            cfg_err     <= 1'b0;
            scale_step  <= 16'(PIXEL_STEP);
            step_sat    <= 1'b0;
            step_upd    <= 1'b0;
        end else begin
            // Rejection and frame-start application both surface one edge
            // after the edge that sampled them.
            err_q    <= accept & cfg_zero;
            cfg_err  <= err_q;
            apply_q  <= (state == ST_PEND) & frame_start;
            step_upd <= 1'b0;

            // pending cannot change within one cycle of leaving PEND (a new
            // division takes NUM_BITS cycles), so it is safe to read here.
            if (apply_q) begin
                scale_step <= pending;
                step_sat   <= pending_sat;
                step_upd   <= 1'b1;
            end

            case (state)
                ST_IDLE: begin
                    if (do_load) begin
                        state <= ST_DIV;
                    end
                end
                ST_DIV: begin
                    num <= {num[NUM_BITS-2:0], 1'b0};
                    rem <= rem_next;
                    quo <= quo_next;
                    cnt <= cnt - 1'b1;
                    if (cnt == '0) begin
                        state <= ST_PEND;
                        if (quo_ext > QW'(16'hFFFF)) begin
                            pending     <= 16'hFFFF;
                            pending_sat <= 1'b1;
                        end else if (quo_next == '0) begin
                            // A zero step would stall the scaler's output counter.
                            pending     <= 16'd1;
                            pending_sat <= 1'b1;
                        end else begin
                            pending     <= quo_ext[15:0];
                            pending_sat <= 1'b0;
                        end
                    end
                end
                ST_PEND: begin
                    if (do_load) begin
                        state <= ST_DIV;
                    end else if (frame_start) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase

            if (do_load) begin
                num <= {cfg_in_width, {PB{1'b0}}};
                den <= cfg_out_width;
                quo <= '0;
                rem <= '0;
                cnt <= CW'(NUM_BITS - 1);
            end
        end
    end

endmodule

// File: tb/tb_scaler_step_ctrl.sv
module tb_scaler_step_ctrl;

    localparam int NB = 25;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [12:0] cfg_in_width = '0;
    logic [12:0] cfg_out_width = '0;
    logic        cfg_valid = 1'b0;
    logic        cfg_ready;
    logic        cfg_err;
    logic        de_i = 1'b0;
    logic        hs_i = 1'b0;
    logic        vs_i = 1'b0;
    logic [15:0] scale_step;
    logic        step_upd;
    logic        step_sat;
    logic        busy;

    int checks = 0;
    int failures = 0;

    scaler_step_ctrl dut (
        .clk(clk), .rst(rst),
        .cfg_in_width(cfg_in_width), .cfg_out_width(cfg_out_width),
        .cfg_valid(cfg_valid), .cfg_ready(cfg_ready), .cfg_err(cfg_err),
        .de_i(de_i), .hs_i(hs_i), .vs_i(vs_i),
        .scale_step(scale_step), .step_upd(step_upd), .step_sat(step_sat),
        .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, got, exp, $time);
        end
    endtask

    // ---------------- behavioural reference model ----------------
    int  m_step, m_sat, m_upd, m_err;
    int  div_left;           // cycles until the running division delivers
    int  res_val, res_sat;   // result of the running division
    int  m_pend, m_pend_sat;
    bit  have_pend, apply_flag, err_stage;

    function automatic void expected_step(input int win, input int wout,
                                          output int val, output int sat);
        longint q;
        q = (longint'(win) * 4096) / longint'(wout);
        if (q > 65535)   begin val = 65535; sat = 1; end
        else if (q == 0) begin val = 1;     sat = 1; end
        else             begin val = int'(q); sat = 0; end
    endfunction

    task automatic model_reset();
        m_step = 4096; m_sat = 0; m_upd = 0; m_err = 0;
        div_left = 0; res_val = 0; res_sat = 0;
        m_pend = 0; m_pend_sat = 0;
        have_pend = 0; apply_flag = 0; err_stage = 0;
    endtask

    initial model_reset();

    always @(posedge clk) begin
        bit s_valid, s_fs, s_rst, acc, zero;
        int s_in, s_out;
        s_valid = cfg_valid; s_in = int'(cfg_in_width); s_out = int'(cfg_out_width);
        s_fs = de_i & vs_i; s_rst = rst;
        if (s_rst) begin
            model_reset();
        end else begin
            m_upd = apply_flag ? 1 : 0;
            if (apply_flag) begin m_step = m_pend; m_sat = m_pend_sat; end
            m_err = err_stage ? 1 : 0;
            acc  = s_valid && (div_left == 0);
            zero = (s_in == 0) || (s_out == 0);
            err_stage  = acc && zero;
            apply_flag = s_fs && have_pend;
            if (have_pend && s_fs) have_pend = 0;
            if (div_left > 0) begin
                div_left--;
                if (div_left == 0) begin
                    m_pend = res_val; m_pend_sat = res_sat; have_pend = 1;
                end
            end
            if (acc && !zero) begin
                expected_step(s_in, s_out, res_val, res_sat);
                div_left = NB;
                have_pend = 0;
            end
        end
        #1;
        chk("m_scale_step", scale_step, m_step);
        chk("m_step_sat", step_sat, m_sat);
        chk("m_step_upd", step_upd, m_upd);
        chk("m_cfg_err", cfg_err, m_err);
        chk("m_busy", busy, (div_left > 0) ? 1 : 0);
        chk("m_cfg_ready", cfg_ready, (div_left > 0) ? 0 : 1);
    end

    // ---------------- directed stimulus helpers ----------------
    task automatic send_cfg(input int win, input int wout);
        @(negedge clk);
        cfg_in_width = 13'(win); cfg_out_width = 13'(wout); cfg_valid = 1'b1;
        @(negedge clk);
        cfg_valid = 1'b0;
    endtask

    task automatic count_busy(input string name);
        int n = 0;
        while (busy && n < 100) begin n++; @(negedge clk); end
        chk(name, n, NB);
    endtask

    task automatic frame();
        de_i = 1'b1; vs_i = 1'b1;
        @(negedge clk);
        de_i = 1'b0; vs_i = 1'b0;
    endtask

    task automatic run_case(input int win, input int wout, input int exp_step,
                            input int exp_sat, input string tag);
        send_cfg(win, wout);
        count_busy({tag, "_busy_len"});
        frame();
        @(negedge clk);
        chk({tag, "_step"}, scale_step, exp_step);
        chk({tag, "_sat"}, step_sat, exp_sat);
        chk({tag, "_upd"}, step_upd, 1);
        @(negedge clk);
        chk({tag, "_upd_off"}, step_upd, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        rst = 1'b0;

        // idle with syncs running
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            de_i = i[0]; vs_i = (i % 5 == 0); hs_i = i[1];
        end
        @(negedge clk);
        de_i = 0; vs_i = 0; hs_i = 0;
        chk("idle_step", scale_step, 4096);
        chk("idle_ready", cfg_ready, 1);
        chk("idle_upd", step_upd, 0);

        run_case(1920, 1280, 6144, 0, "c1920_1280");
        run_case(1280, 1920, 2730, 0, "c1280_1920");
        run_case(8191, 1, 65535, 1, "c8191_1");
        run_case(1, 8191, 1, 1, "c1_8191");

        // zero widths rejected
        send_cfg(100, 0);
        chk("err0_busy", busy, 0);
        @(negedge clk);
        chk("err0_pulse", cfg_err, 1);
        @(negedge clk);
        chk("err0_off", cfg_err, 0);
        chk("err0_step", scale_step, 1);
        send_cfg(0, 5);
        chk("err1_busy", busy, 0);
        @(negedge clk);
        chk("err1_pulse", cfg_err, 1);

        // last config wins; rejected config and vs-only leave pending alone
        send_cfg(1920, 1280);
        count_busy("two_a_busy");
        send_cfg(640, 1280);
        count_busy("two_b_busy");
        send_cfg(0, 0);
        vs_i = 1'b1;
        @(negedge clk);
        vs_i = 1'b0;
        repeat (2) @(negedge clk);
        chk("vs_only_step", scale_step, 1);
        chk("vs_only_upd", step_upd, 0);
        frame();
        @(negedge clk);
        chk("two_step", scale_step, 2048);
        chk("two_upd", step_upd, 1);

        // reset mid-division
        send_cfg(1920, 1280);
        repeat (10) @(negedge clk);
        rst = 1'b1;
        #1;
        chk("rst_step", scale_step, 4096);
        chk("rst_busy", busy, 0);
        chk("rst_ready", cfg_ready, 1);
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        frame();
        repeat (2) @(negedge clk);
        chk("rst_frame_step", scale_step, 4096);

        // randomized traffic against the model
        for (int i = 0; i < 4000; i++) begin
            @(negedge clk);
            rst = ($urandom_range(0, 999) == 0);
            cfg_valid = ($urandom_range(0, 7) == 0);
            cfg_in_width  = ($urandom_range(0, 9) == 0) ? 13'd0 : 13'($urandom_range(1, 8191));
            cfg_out_width = ($urandom_range(0, 9) == 0) ? 13'd0 : 13'($urandom_range(1, 8191));
            de_i = $urandom_range(0, 1) == 1;
            vs_i = ($urandom_range(0, 19) == 0);
            hs_i = $urandom_range(0, 1) == 1;
        end
        @(negedge clk);
        rst = 0; cfg_valid = 0; de_i = 0; vs_i = 0; hs_i = 0;
        repeat (3) @(negedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
